// File: rtl/afifo_rd_stream_if.sv
// Interface for the async FIFO read port and the rclk-domain valid/ready stream
// that afifo_rd_stream re-presents it on.
// master: the afifo_rd_stream side (pops the FIFO, drives the stream).
// slave:  the environment side (FIFO read port plus downstream sink).
interface afifo_rd_stream_if #(
  parameter int Width = 12
);
  logic [Width-1:0] fifo_rd;
  logic             fifo_rempty;
  logic             fifo_r;
  logic             out_valid;
  logic [Width-1:0] out_data;
  logic             out_ready;

  modport master (
    input  fifo_rd, fifo_rempty, out_ready,
    output fifo_r, out_valid, out_data
  );

  modport slave (
    output fifo_rd, fifo_rempty, out_ready,
    input  fifo_r, out_valid, out_data
  );
endinterface

// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: pops show-ahead words from the async FIFO read port and
// re-presents them on a registered valid/ready stream via a 2-entry skid buffer.
// Optional feature macro SEQCHK_EN: adds an incrementing-sequence checker on
// delivered words (seq_err/seq_exp); without it those outputs are tied to 0.
module afifo_rd_stream #(
  parameter int Width      = 12,
  parameter int CountWidth = 16
) (
  input  logic                  rclk,
  input  logic                  dirclr,
  input  logic                  flush,
  afifo_rd_stream_if.master     bus,
  output logic [CountWidth-1:0] word_count,
  output logic                  seq_err,
  output logic [Width-1:0]      seq_exp
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [Width-1:0]      entry0_q, entry0_d;
  logic [Width-1:0]      entry1_q, entry1_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  out_valid;
  logic                  push;
  logic                  pop;

  // Pop the FIFO whenever a word is there and the buffer has room; the sink's
  // ready never feeds this path, which is what the second entry absorbs.
  assign push = !bus.fifo_rempty && (state_q != TWO) && !flush && !dirclr;
  assign out_valid = (state_q != EMPTY);
  assign pop = out_valid && bus.out_ready;

  assign bus.fifo_r    = push;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = entry0_q;
  assign word_count    = count_q;

  // Buffer occupancy register plus the two data entries.
  always_ff @(posedge rclk or posedge dirclr) begin
    if (dirclr) begin
      state_q  <= EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  // Next occupancy and entry moves; flush empties the buffer regardless.
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d  = ONE;
          entry0_d = bus.fifo_rd;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d  = TWO;
          entry1_d = bus.fifo_rd;
        end else if (push && pop) begin
          entry0_d = bus.fifo_rd;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d  = ONE;
          entry0_d = entry1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // Saturating count of stream transfers; a pop coinciding with flush is not counted.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (pop && (count_q != {CountWidth{1'b1}})) begin
      count_d = count_q + CountWidth'(1);
    end
  end

`ifdef SEQCHK_EN
  logic             seq_armed_q, seq_armed_d;
  logic [Width-1:0] seq_ref_q, seq_ref_d;
  logic             seq_err_q, seq_err_d;
  logic [Width-1:0] seq_exp_q, seq_exp_d;
  logic [Width-1:0] seq_next;

  assign seq_next = seq_ref_q + Width'(1);
  assign seq_err  = seq_err_q;
  assign seq_exp  = seq_exp_q;

  // Checker state: armed means the next delivered word only seeds the reference.
  always_ff @(posedge rclk or posedge dirclr) begin
    if (dirclr) begin
      seq_armed_q <= 1'b1;
      seq_ref_q   <= '0;
      seq_err_q   <= 1'b0;
      seq_exp_q   <= '0;
    end else begin
      seq_armed_q <= seq_armed_d;
      seq_ref_q   <= seq_ref_d;
      seq_err_q   <= seq_err_d;
      seq_exp_q   <= seq_exp_d;
    end
  end

  // Compare each delivered word to ref+1 (wrapping); latch only the first miss.
  always_comb begin
    seq_armed_d = seq_armed_q;
    seq_ref_d   = seq_ref_q;
    seq_err_d   = seq_err_q;
    seq_exp_d   = seq_exp_q;
    if (flush) begin
      seq_armed_d = 1'b1;
      seq_err_d   = 1'b0;
      seq_exp_d   = '0;
    end else if (pop) begin
      seq_ref_d = entry0_q;
      if (seq_armed_q) begin
        seq_armed_d = 1'b0;
      end else if (!seq_err_q && (entry0_q != seq_next)) begin
        seq_err_d = 1'b1;
        seq_exp_d = seq_next;
      end
    end
  end
`else
  assign seq_err = 1'b0;
  assign seq_exp = '0;
`endif

endmodule
